vend_coin_sequencer: RTL and testbench

//  Front-end controller for vending_machine. Queues single-cycle coin pulses from the

---
 rtl/vend_coin_sequencer.sv | 130 +++++++++++++
 tb/tb_vend_coin_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vend_coin_sequencer.sv
// Coin front-end for vending_machine: queues button coin pulses, issues them one
// at a time as 1-cycle codes, and tallies sales and change seen in each response window.
module vend_coin_sequencer #(
    parameter int DEPTH     = 4,
    parameter int PTR_W     = 2,
    parameter int RESP_WAIT = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin1,
    input  logic             coin2,
    output logic [1:0]       vm_in,
    input  logic             vm_out,
    input  logic [1:0]       vm_change,
    output logic             busy,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [PTR_W:0]   level,
    output logic             drop,
    output logic [CNT_W-1:0] sale_cnt,
    output logic [CNT_W-1:0] change_cnt
);
    localparam int WC_W = $clog2(RESP_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state, state_nx;
    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [1:0]       wcode, vm_in_nx;
    logic             push, pop, rej;
    logic [WC_W-1:0]  wcnt, wcnt_nx;
    logic             seen, seen_nx, hit;
    logic [CNT_W-1:0] sale_nx, change_nx;
    logic [CNT_W:0]   change_sum;

    assign fifo_full  = (level == (PTR_W+1)'(DEPTH));
    assign fifo_empty = (level == '0);
    assign busy       = (state != IDLE);

    // Fullness is judged on the pre-edge level, so a same-edge pop never frees a slot.
    always_comb begin
        wcode = coin2 ? 2'b10 : 2'b01;
        push  = (coin1 || coin2) && !fifo_full;
        rej   = (coin1 && coin2) || ((coin1 || coin2) && fifo_full);
    end

    always_comb begin
        state_nx = state;
        vm_in_nx = 2'b00;
        pop      = 1'b0;
        wcnt_nx  = wcnt;
        seen_nx  = seen;
        hit      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    vm_in_nx = mem[rptr];
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                wcnt_nx  = WC_W'(RESP_WAIT);
                seen_nx  = 1'b0;
                state_nx = WAIT;
            end
            WAIT: begin
                wcnt_nx = wcnt - 1'b1;
                if (vm_out && !seen) begin
                    hit     = 1'b1;
                    seen_nx = 1'b1;
                end
                if (wcnt == WC_W'(1))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Saturating tallies; change adds up to 3 per sale so clamp on carry-out.
    always_comb begin
        sale_nx    = sale_cnt;
        change_nx  = change_cnt;
        change_sum = {1'b0, change_cnt} + {{(CNT_W-1){1'b0}}, vm_change};
        if (hit) begin
            if (sale_cnt != '1)
                sale_nx = sale_cnt + 1'b1;
            change_nx = change_sum[CNT_W] ? '1 : change_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wcode;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vm_in      <= 2'b00;
            wptr       <= '0;
            rptr       <= '0;
            level      <= '0;
            drop       <= 1'b0;
            wcnt       <= '0;
            seen       <= 1'b0;
            sale_cnt   <= '0;
            change_cnt <= '0;
        end else begin
            state      <= state_nx;
            vm_in      <= vm_in_nx;
            wcnt       <= wcnt_nx;
            seen       <= seen_nx;
            drop       <= rej;
            sale_cnt   <= sale_nx;
            change_cnt <= change_nx;
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: tb/tb_vend_coin_sequencer.sv
// Directed bench for vend_coin_sequencer with default parameters (DEPTH=4, RESP_WAIT=2).
module tb_vend_coin_sequencer;
    logic       clk = 1'b0;
    logic       rst, coin1, coin2, vm_out;
    logic [1:0] vm_change, vm_in;
    logic       busy, fifo_full, fifo_empty, drop;
    logic [2:0] level;
    logic [7:0] sale_cnt, change_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    vend_coin_sequencer dut (
        .clk(clk), .rst(rst), .coin1(coin1), .coin2(coin2),
        .vm_in(vm_in), .vm_out(vm_out), .vm_change(vm_change),
        .busy(busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .level(level), .drop(drop), .sale_cnt(sale_cnt), .change_cnt(change_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One coin from an idle, empty sequencer; vm_out/vm_change held over both WAIT edges.
    task automatic issue_coin(input logic c1, input logic c2, input int code,
                              input logic out, input logic [1:0] chg);
        coin1 = c1; coin2 = c2;
        tick();
        coin1 = 0; coin2 = 0;
        tick();
        chk("issue_code", vm_in, code);
        tick();
        vm_out = out; vm_change = chg;
        tick();
        tick();
        vm_out = 0; vm_change = 0;
        chk("issue_back_idle", busy, 0);
    endtask

    initial begin
        int codes, drops, last, gaps_bad, nz;
        rst = 1; coin1 = 0; coin2 = 0; vm_out = 0; vm_change = 0;
        tick(); tick();
        chk("rst_vm_in", vm_in, 0);
        chk("rst_level", level, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_drop", drop, 0);
        chk("rst_busy", busy, 0);
        rst = 0;

        // Idle with no coins
        nz = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (vm_in != 0 || busy || level != 0) nz++;
        end
        chk("idle_quiet", nz, 0);
        chk("idle_sale", sale_cnt, 0);
        chk("idle_change", change_cnt, 0);

        // Single coin1: timing of code and busy window
        coin1 = 1;
        tick();
        coin1 = 0;
        chk("c1_level", level, 1);
        chk("c1_vm_in_E", vm_in, 0);
        tick();
        chk("c1_vm_in_E1", vm_in, 1);
        chk("c1_busy_E1", busy, 1);
        chk("c1_level_pop", level, 0);
        tick();
        chk("c1_vm_in_E2", vm_in, 0);
        chk("c1_busy_E2", busy, 1);
        tick();
        chk("c1_busy_E3", busy, 1);
        tick();
        chk("c1_busy_E4", busy, 0);
        issue_coin(1, 0, 1, 0, 2'b00);
        issue_coin(1, 0, 1, 1, 2'b00);
        chk("sale_after_3", sale_cnt, 1);
        chk("change_after_3", change_cnt, 0);

        // Six consecutive coin1 pulses into a 4-deep FIFO
        codes = 0; drops = 0; last = -1; gaps_bad = 0;
        for (int i = 0; i < 30; i++) begin
            coin1 = (i < 6);
            tick();
            if (i == 4) begin
                chk("burst_full", fifo_full, 1);
                chk("burst_level4", level, 4);
            end
            if (i == 5) chk("burst_level_e6", level, 3);
            if (vm_in == 2'b01) begin
                if (last >= 0 && i - last != 4) gaps_bad++;
                last = i;
                codes++;
            end else if (vm_in != 0) gaps_bad++;
            if (drop) begin
                drops++;
                chk("burst_drop_cycle", i, 5);
            end
        end
        coin1 = 0;
        chk("burst_codes", codes, 5);
        chk("burst_drops", drops, 1);
        chk("burst_gaps", gaps_bad, 0);
        chk("burst_empty", fifo_empty, 1);

        // coin1 and coin2 together
        coin1 = 1; coin2 = 1;
        tick();
        coin1 = 0; coin2 = 0;
        chk("both_drop", drop, 1);
        chk("both_level", level, 1);
        tick();
        chk("both_code", vm_in, 2);
        chk("both_drop_clr", drop, 0);
        chk("both_level0", level, 0);
        tick(); tick(); tick();
        chk("both_idle", busy, 0);

        // vm_out held across both WAIT edges counts once
        issue_coin(0, 1, 2, 1, 2'b01);
        chk("once_sale", sale_cnt, 2);
        chk("once_change", change_cnt, 1);

        // Reset while waiting with three coins queued
        for (int i = 0; i < 4; i++) begin
            coin1 = 1;
            tick();
        end
        coin1 = 0;
        chk("pre_rst_level", level, 3);
        chk("pre_rst_busy", busy, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_vm_in", vm_in, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_sale", sale_cnt, 0);
        chk("mid_rst_change", change_cnt, 0);
        nz = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (vm_in != 0 || busy) nz++;
        end
        chk("post_rst_quiet", nz, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
